fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/fetch_stage_if.sv | 18 +
 rtl/fetch_skid_buf.sv | 34 +++
 rtl/fetch_stage.sv | 129 ++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the pipeline stages.
//   WORD          - datapath width
//   word_t        - one datapath word
//   NOP           - encoding used for bubbles in the F/D register
//   fetch_state_e - fetch FSM state encoding
package cpu_pkg;

  localparam int WORD = 32;

  typedef logic [WORD-1:0] word_t;

  localparam word_t NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_FETCH = 2'd0,
    FS_WAIT  = 2'd1,
    FS_KILL  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/ack bus.
//   imemReq   - fetch side requests a read
//   imemAddr  - read address, stable until imemAck
//   imemAck   - read data valid this cycle
//   imemRdata - instruction word
// Modports: master (fetch stage), slave (instruction memory).
interface fetch_stage_if;
  import cpu_pkg::*;

  logic  imemReq;
  word_t imemAddr;
  logic  imemAck;
  word_t imemRdata;

  modport master (output imemReq, imemAddr, input imemAck, imemRdata);
  modport slave  (input imemReq, imemAddr, output imemAck, imemRdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: one-entry holding register for an instruction word that
// arrived while the pipeline could not accept it.
//   clk, rst_n - clock, async active-low reset
//   load       - store din and mark full
//   consume    - entry taken by the F/D register this cycle
//   clear      - discard the entry (redirect / flush)
//   din        - incoming instruction word
//   full, dout - entry valid flag and stored word
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  consume,
  input  logic  clear,
  input  word_t din,
  output logic  full,
  output word_t dout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      dout <= NOP;
    end else if (clear || consume) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, instruction-memory request FSM and F/D register.
// Parameter RESET_PC: PC loaded on reset.
// Ports:
//   clk, rst_n             - pipeline clock, async active-low reset
//   stallF, stallD, flushD - hazard unit requests
//   pcRedirectD, pcTargetD - control change resolved in Decode
//   imem                   - instruction-memory bus (master)
//   instrD, pcD, pcPlus4D  - F/D register contents
//   validD                 - F/D register holds a real instruction
//   fetchBusy              - FSM in WAIT or KILL
// Build option FETCH_SKID_EN: adds a 1-entry skid buffer so an ack arriving
// during a stall is kept instead of being re-requested.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  stallF,
  input  logic  stallD,
  input  logic  flushD,
  input  logic  pcRedirectD,
  input  word_t pcTargetD,
  fetch_stage_if.master imem,
  output word_t instrD,
  output word_t pcD,
  output word_t pcPlus4D,
  output logic  validD,
  output logic  fetchBusy
);

  fetch_state_e state;
  word_t        pcF;
  logic         adv;
  logic         redirect;
  logic         ack_live;
  logic         capture;
  word_t        cap_data;

  assign adv      = !stallF && !stallD;
  assign redirect = pcRedirectD && adv;

`ifdef FETCH_SKID_EN
  logic  skid_full;
  logic  skid_load;
  word_t skid_data;

  // No request is presented while the buffer is full, so any ack then is ignored.
  assign imem.imemReq = !skid_full;
  assign ack_live     = imem.imemAck && !skid_full;
  assign skid_load    = ack_live && !adv && (state != FS_KILL);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .consume (adv),
    .clear   (flushD || redirect),
    .din     (imem.imemRdata),
    .full    (skid_full),
    .dout    (skid_data)
  );

  assign capture  = adv && (skid_full || (ack_live && (state != FS_KILL)));
  assign cap_data = skid_full ? skid_data : imem.imemRdata;
`else
  assign imem.imemReq = 1'b1;
  assign ack_live     = imem.imemAck;
  assign capture      = ack_live && adv && (state != FS_KILL);
  assign cap_data     = imem.imemRdata;
`endif

  assign imem.imemAddr = pcF;
  assign fetchBusy     = (state == FS_WAIT) || (state == FS_KILL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FS_FETCH;
      pcF   <= RESET_PC;
    end else begin
      if (redirect)
        pcF <= pcTargetD;
      else if (capture)
        pcF <= pcF + 32'd4;

      case (state)
        FS_FETCH, FS_WAIT: begin
          // With no request presented nothing is outstanding, so stay in FETCH.
          if (ack_live || !imem.imemReq)
            state <= FS_FETCH;
          else if (redirect)
            state <= FS_KILL;   // in-flight word belongs to the old path
          else
            state <= FS_WAIT;
        end
        FS_KILL: begin
          if (ack_live)
            state <= FS_FETCH;
        end
        default: state <= FS_FETCH;
      endcase
    end
  end

  // F/D register: flush beats stall, stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instrD   <= NOP;
      pcD      <= '0;
      pcPlus4D <= '0;
      validD   <= 1'b0;
    end else if (flushD) begin
      instrD <= NOP;
      validD <= 1'b0;
    end else if (!stallD) begin
      if (capture) begin
        instrD   <= cap_data;
        pcD      <= pcF;
        pcPlus4D <= pcF + 32'd4;
        validD   <= 1'b1;
      end else begin
        instrD <= NOP;
        validD <= 1'b0;
      end
    end
  end

endmodule
